simplez_uart_tx: RTL and testbench
==================================

# simplez_uart_tx

Memory-mapped serial transmitter peripheral for the Simplez microcontroller, sitting downstream of the CPU on its external address/data path, alongside the LED port at 9'o100. Each `ST` to the data address pushes the low byte of the data bus into a small FIFO. An 8N1 serialiser drains the FIFO onto `tx`. A status word at a second address lets programs poll for space and detect overflow.

## Interface
- `BAUD_DIV`, 104: clock cycles per serial bit; legal range is 2 or more.
- `ADDR_DATA`, 9'o101: write-only data address.
- `ADDR_STAT`, 9'o102: status address; reads return status, writes clear flags.
- `FIFO_AW`, 2: FIFO depth is 2^FIFO_AW, so 4 entries by default.

Ports:
- `clk`  in  1  system clock; all state updates on the falling edge, as in the CPU.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  9  CPU address register (RA).
- `data_in`  in  12  CPU data bus (busD).
- `wr`  in  1  write strobe (the CPU's `esc`).
- `data_out`  out  12  read data: status word when `addr`==ADDR_STAT, otherwise 12'd0. Combinational.
- `tx`  out  1  serial line; idle level is high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.

## Operation
- Status word: {9'b0, ovf, full, busy}. `full` is bit 1 and `ovf` is bit 2.
- Push: on a falling edge with `wr`=1 and `addr`==ADDR_DATA, `data_in[7:0]` enters the FIFO. `data_in[11:8]` is ignored.
- Push when full: the byte is dropped, the FIFO is unchanged, and sticky `ovf` is set.
- Exception: when a push and a pop occur on the same edge with the FIFO full, the push is accepted and `ovf` is not set.
- Clearing overflow: a write to ADDR_STAT with `data_in[2]`=1 clears `ovf`.
  - If an overflowing push happens on the same edge, it cannot, because the address differs; set and clear are therefore exclusive.
- Writes to any other address are ignored.
- FIFO storage:
  - Circular buffer with FIFO_AW-bit read and write pointers that wrap.
  - An occupancy counter of FIFO_AW+1 bits.
  - `full` means the count equals 2^FIFO_AW; empty means the count is 0.
- Serialiser state machine, with state and counters on the falling edge:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into shift register `sh`, load the baud counter, and go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=`sh[0]`, LSB first. Each bit lasts BAUD_DIV cycles; then shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- The baud counter counts BAUD_DIV-1 down to 0; the bit period ends on the edge at which the counter is 0.
- `tx` is driven from a register, so it is glitch-free.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `data_out`=0, `ovf`=0.
  - FIFO empty with pointers at 0.
  - State IDLE; all counters at 0.
- Reset mid-frame: `tx` returns high immediately (asynchronous) and any queued bytes are discarded.
- Write latency: for a push at falling edge N with the serialiser in IDLE and the FIFO previously empty:
  - The pop happens at edge N+1 and `tx` falls at edge N+1.
  - `busy` rises at edge N.
- Frame length: exactly 10·BAUD_DIV cycles from the falling edge of `tx` (start bit) to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the same edge that ends the previous stop bit.
- `busy` falls at the edge that ends the last stop bit with the FIFO empty.
- `data_out` is valid in the same cycle that `addr` is presented, matching the CPU's read in state O1.

## Test plan
- Single byte: with BAUD_DIV=4, write 12'h055 to 9'o101.
  - Required: `tx` low at the next edge, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles.
  - `busy` low after 40 cycles; upper nibble ignored.
- Back-to-back: write 8'hA5 and then 8'h3C on consecutive CPU writes.
  - Required: two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit.
- Overflow: six consecutive pushes of 1..6.
  - Required: bytes 1–5 transmitted in order; byte 6 dropped.
  - `full`=1 after the 5th push; status reads 12'h007 while sending.
  - Write 12'h004 to 9'o102, then after drain status reads 12'h000.
- Full with simultaneous pop: with the FIFO full, push on the edge where STOP ends.
  - Required: the byte is accepted and `ovf` stays 0.
- Address decode: writes to 9'o100 and 9'o103.
  - Required: `tx` stays 1, `busy` stays 0, and `data_out` reads 0 at those addresses.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - Required: `tx`=1 immediately, `busy`=0, FIFO empty.
  - After release, a fresh write transmits correctly.

Source files
------------

// File: rtl/simplez_uart_tx.sv
// simplez_uart_tx: memory-mapped 8N1 serial transmitter for the Simplez CPU.
// A small circular FIFO feeds a falling-edge serialiser that drives tx.
module simplez_uart_tx #(
    parameter int         BAUD_DIV  = 104,
    parameter logic [8:0] ADDR_DATA = 9'o101,
    parameter logic [8:0] ADDR_STAT = 9'o102,
    parameter int         FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  addr,
    input  logic [11:0] data_in,
    input  logic        wr,
    output logic [11:0] data_out,
    output logic        tx,
    output logic        busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int BW    = $clog2(BAUD_DIV);

    localparam logic [BW-1:0]    BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]    BAUD_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Serialiser registers
    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_idx;
    logic [7:0]      r_sh;
    logic            r_tx;

    // FIFO registers
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    // Next-state and decode wires
    state_t          w_state_nxt;
    logic [BW-1:0]   w_baud_nxt;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      w_sh_nxt;
    logic            w_tx_nxt;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_empty;
    logic            w_full;
    logic            w_busy;
    logic [7:0]      w_head;
    logic            w_baud_done;
    logic            w_unused_hi;

    // The high nibble of the data bus carries no meaning for this port
    assign w_unused_hi = ^data_in[11:8];

    // FIFO status and head-of-queue view
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_head  = r_mem[r_rptr];

    // Bus write decode; a full FIFO still accepts when a pop frees a slot
    assign w_push_req = wr && (addr == ADDR_DATA);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = wr && (addr == ADDR_STAT) && data_in[2];

    assign w_baud_done = (r_baud == '0);

    // Busy covers an active frame as well as anything still queued
    assign w_busy = (r_state != S_IDLE) || !w_empty;

    // Combinational status read, valid in the cycle addr is presented
    always_comb begin
        data_out = 12'd0;
        if (addr == ADDR_STAT) begin
            data_out = {9'b0, r_ovf, w_full, w_busy};
        end
    end

    assign tx   = r_tx;
    assign busy = w_busy;

    // Serialiser next-state, pop request and registered tx level
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_head;
                    w_baud_nxt  = BAUD_LOAD;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = BAUD_LOAD;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = BAUD_LOAD;
                    w_sh_nxt   = {1'b0, r_sh[7:1]};
                    w_idx_nxt  = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit
                        w_pop       = 1'b1;
                        w_sh_nxt    = w_head;
                        w_baud_nxt  = BAUD_LOAD;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        unique case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_sh_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // Serialiser state register, updated on the CPU's falling edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_idx   <= 3'd0;
            r_sh    <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(negedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in[7:0];
        end
    end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// tb_simplez_uart_tx: random and directed bench for simplez_uart_tx.
// Outputs are compared every rising edge against a frame-timer model.
module tb_simplez_uart_tx;

    localparam int B     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * B;
    localparam logic [8:0] A_DATA = 9'o101;
    localparam logic [8:0] A_STAT = 9'o102;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr;
    logic [11:0] data_in;
    logic        wr;
    logic [11:0] data_out;
    logic        tx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    simplez_uart_tx #(
        .BAUD_DIV (B),
        .ADDR_DATA(A_DATA),
        .ADDR_STAT(A_STAT),
        .FIFO_AW  (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wr      (wr),
        .data_out(data_out),
        .tx      (tx),
        .busy    (busy)
    );

    function automatic void chk(input string name, input logic [11:0] act,
                                input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    byte unsigned mq[$];
    bit           m_active;
    int           m_t;
    logic [7:0]   m_cur;
    bit           m_ovf;
    bit           m_ends;
    bit           m_pop;
    byte unsigned m_hd;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_cur    = 8'd0;
            m_ovf    = 1'b0;
        end else begin
            m_ends = m_active && (m_t == FRAME - 1);
            m_pop  = (mq.size() > 0) && (!m_active || m_ends);
            m_hd   = 8'd0;
            if (m_pop) m_hd = mq.pop_front();
            if (wr && addr == A_DATA) begin
                if (mq.size() < DEPTH) mq.push_back(data_in[7:0]);
                else m_ovf = 1'b1;
            end
            if (wr && addr == A_STAT && data_in[2]) m_ovf = 1'b0;
            if (m_pop) begin
                m_active = 1'b1;
                m_t      = 0;
                m_cur    = m_hd;
            end else if (m_ends) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
            end
        end
    end

    function automatic logic m_tx();
        int sym;
        if (!m_active) return 1'b1;
        sym = m_t / B;
        if (sym == 0) return 1'b0;
        if (sym <= 8) return m_cur[sym-1];
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_active || (mq.size() > 0);
    endfunction

    function automatic logic [11:0] m_dout();
        logic full;
        full = (mq.size() == DEPTH);
        if (addr != A_STAT) return 12'd0;
        return {9'b0, m_ovf, full, m_busy()};
    endfunction

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        if (chk_en && !rst) begin
            chk("tx", 12'(tx), 12'(m_tx()));
            chk("busy", 12'(busy), 12'(m_busy()));
            chk("data_out", data_out, m_dout());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic [8:0] a, input logic [11:0] d);
        @(posedge clk);
        #2;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic wait_idle(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(posedge clk);
            if (!busy) break;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, max);
        end
    endtask

    task automatic wait_bit(input int sym, input bit need_full, input int max);
        int i;
        bit ok;
        ok = 1'b0;
        for (i = 0; i < max; i++) begin
            @(posedge clk);
            if (m_active && (m_t / B == sym) &&
                (sym != 9 || m_t == FRAME - 1) &&
                (!need_full || mq.size() == DEPTH)) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_bit: symbol %0d not reached in %0d cycles", sym, max);
        end
    endtask

    logic [9:0]  sym1;
    logic [19:0] sym2;
    int r;

    initial begin
        rst = 1'b1; wr = 1'b0; addr = A_STAT; data_in = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 12'(tx), 12'd1);
        chk("rst_busy", 12'(busy), 12'd0);
        chk("rst_status", data_out, 12'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Single byte, 0x55: start, 1,0,1,0,1,0,1,0, stop
        sym1 = {1'b1, 8'h55, 1'b0};
        drive(1'b1, A_DATA, 12'h055);
        drive(1'b0, 9'd0, 12'd0);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            chk("t1_tx", 12'(tx), 12'(sym1[k/B]));
            chk("t1_busy", 12'(busy), 12'd1);
        end
        @(posedge clk);
        chk("t1_busy_end", 12'(busy), 12'd0);
        chk("t1_tx_end", 12'(tx), 12'd1);

        // Back-to-back 0xA5 then 0x3C, contiguous frames
        sym2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        drive(1'b1, A_DATA, 12'hFA5);
        drive(1'b1, A_DATA, 12'h03C);
        drive(1'b0, 9'd0, 12'd0);
        for (int k = 1; k < 2 * FRAME; k++) begin
            @(posedge clk);
            chk("t2_tx", 12'(tx), 12'(sym2[k/B]));
        end
        @(posedge clk);
        chk("t2_busy_end", 12'(busy), 12'd0);

        // Overflow: six pushes, the sixth is dropped
        for (int i = 1; i <= 6; i++) drive(1'b1, A_DATA, 12'(i));
        drive(1'b0, A_STAT, 12'd0);
        #1 chk("ovf_status", data_out, 12'h007);
        drive(1'b1, A_STAT, 12'h004);
        drive(1'b0, A_STAT, 12'd0);
        #1 chk("ovf_cleared", data_out, 12'h003);
        wait_idle(8 * FRAME);
        #1 chk("ovf_drained", data_out, 12'h000);

        // Full FIFO with a push on the edge that ends STOP
        for (int i = 0; i < 5; i++) drive(1'b1, A_DATA, 12'(8'h11 * (i + 1)));
        drive(1'b0, 9'd0, 12'd0);
        wait_bit(9, 1'b1, 3 * FRAME);
        #2;
        wr = 1'b1; addr = A_DATA; data_in = 12'h066;
        drive(1'b0, A_STAT, 12'd0);
        #1 chk("simul_status", data_out, 12'h003);
        wait_idle(8 * FRAME);
        #1 chk("simul_drained", data_out, 12'h000);

        // Writes to neighbouring addresses do nothing
        drive(1'b1, 9'o100, 12'hFFF);
        drive(1'b1, 9'o103, 12'h0FF);
        drive(1'b0, 9'o100, 12'd0);
        #1 chk("dec_100_dout", data_out, 12'd0);
        chk("dec_tx", 12'(tx), 12'd1);
        chk("dec_busy", 12'(busy), 12'd0);
        drive(1'b0, 9'o103, 12'd0);
        #1 chk("dec_103_dout", data_out, 12'd0);
        repeat (4) @(posedge clk);
        chk("dec_busy_later", 12'(busy), 12'd0);

        // Reset during data bit 3 with a byte still queued
        drive(1'b1, A_DATA, 12'h05A);
        drive(1'b1, A_DATA, 12'h077);
        drive(1'b0, A_STAT, 12'd0);
        wait_bit(4, 1'b0, 2 * FRAME);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 12'(tx), 12'd1);
        chk("mid_rst_busy", 12'(busy), 12'd0);
        chk("mid_rst_status", data_out, 12'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b1, A_DATA, 12'h0C3);
        drive(1'b0, 9'd0, 12'd0);
        @(posedge clk);
        chk("post_rst_start", 12'(tx), 12'd0);
        wait_idle(2 * FRAME);

        // Random traffic, sparse then dense
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < ((i < 1500) ? 3 : 9))
                drive(1'b1, A_DATA, 12'($urandom));
            else if (r < 12)
                drive(1'b1, A_STAT, 12'($urandom));
            else if (r < 15)
                drive(1'b1, 9'($urandom), 12'($urandom));
            else
                drive(1'b0, 9'(9'o100 + $urandom_range(0, 3)), 12'($urandom));
        end
        drive(1'b0, A_STAT, 12'd0);
        wait_idle(8 * FRAME);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
